sensor_fault_monitor: RTL and testbench

Sequential stage downstream of the combinational sensor error detector. Synchronizes the raw 4-bit sensor bus, evaluates the standard error condition, and debounces it over a programmable number of consecutive cycles. Latches a qualified fault until software clears it, and keeps a saturating count of qualified fault events for the status register block.

---
 rtl/sensor_pkg.sv | 23 ++
 rtl/sensor_sync.sv | 32 +++
 rtl/sensor_fault_monitor.sv | 106 ++++++++++
 tb/tb_sensor_fault_monitor.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/sensor_pkg.sv
// Shared definitions for the sensor fault monitor: FSM states, sensor bit
// positions and the error pattern evaluated on the synchronized bus.
package sensor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        QUAL  = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam int SENSOR_W = 4;
    localparam int DEB_W    = 8;

    localparam int S0_IDX = 0;
    localparam int S1_IDX = 1;
    localparam int S2_IDX = 2;
    localparam int S3_IDX = 3;

    function automatic logic sensor_err(input logic [SENSOR_W-1:0] s);
        return s[S0_IDX] | (s[S1_IDX] & (s[S2_IDX] | s[S3_IDX]));
    endfunction

endpackage

// File: rtl/sensor_sync.sv
// Two-flop synchronizer per bit for bringing the asynchronous sensor bus
// into the clk domain.
module sensor_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    r_meta[gi] <= 1'b0;
                    r_sync[gi] <= 1'b0;
                end else begin
                    r_meta[gi] <= async_in[gi];
                    r_sync[gi] <= r_meta[gi];
                end
            end
        end
    endgenerate

    assign sync_out = r_sync;

endmodule

// File: rtl/sensor_fault_monitor.sv
// Debounces the synchronized sensor error condition, latches a qualified
// fault until acknowledged, and keeps a saturating fault event count.
module sensor_fault_monitor
    import sensor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_WIDTH       = 8
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [3:0]           sensors,
    input  logic                 enable,
    input  logic                 clear,
    output logic                 error_live,
    output logic                 fault,
    output logic [CNT_WIDTH-1:0] fault_count
);

    localparam logic [DEB_W-1:0] DEB_TARGET = DEB_W'(DEBOUNCE_CYCLES);

    logic [SENSOR_W-1:0]  w_sync;
    logic                 w_err;
    logic [DEB_W-1:0]     w_deb_inc;
    logic [CNT_WIDTH-1:0] w_cnt_sat;

    state_t               r_state;
    logic [DEB_W-1:0]     r_deb_cnt;
    logic                 r_fault;
    logic [CNT_WIDTH-1:0] r_fault_count;

    sensor_sync #(
        .WIDTH(SENSOR_W)
    ) u_sync (
        .clk     (clk),
        .n_rst   (n_rst),
        .async_in(sensors),
        .sync_out(w_sync)
    );

    assign w_err     = sensor_err(w_sync);
    assign w_deb_inc = r_deb_cnt + DEB_W'(1);
    // Count holds at all-ones instead of wrapping.
    assign w_cnt_sat = (r_fault_count == {CNT_WIDTH{1'b1}}) ? r_fault_count
                                                            : r_fault_count + CNT_WIDTH'(1);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state       <= IDLE;
            r_deb_cnt     <= '0;
            r_fault       <= 1'b0;
            r_fault_count <= '0;
        end else if (!enable) begin
            r_state   <= IDLE;
            r_deb_cnt <= '0;
            r_fault   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_err) begin
                        if (DEB_TARGET == DEB_W'(1)) begin
                            r_state       <= FAULT;
                            r_fault       <= 1'b1;
                            r_fault_count <= w_cnt_sat;
                            r_deb_cnt     <= '0;
                        end else begin
                            r_state   <= QUAL;
                            r_deb_cnt <= DEB_W'(1);
                        end
                    end else begin
                        r_deb_cnt <= '0;
                    end
                end
                QUAL: begin
                    if (!w_err) begin
                        r_state   <= IDLE;
                        r_deb_cnt <= '0;
                    end else if (w_deb_inc == DEB_TARGET) begin
                        r_state       <= FAULT;
                        r_fault       <= 1'b1;
                        r_fault_count <= w_cnt_sat;
                        r_deb_cnt     <= '0;
                    end else begin
                        r_deb_cnt <= w_deb_inc;
                    end
                end
                FAULT: begin
                    // An acknowledge is only honoured once the error has gone away.
                    if (clear && !w_err) begin
                        r_state <= IDLE;
                        r_fault <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_deb_cnt <= '0;
                    r_fault   <= 1'b0;
                end
            endcase
        end
    end

    assign error_live  = w_err;
    assign fault       = r_fault;
    assign fault_count = r_fault_count;

endmodule

// File: tb/tb_sensor_fault_monitor.sv
// Directed and random checks of sensor_fault_monitor against a cycle-level
// behavioural model; a second instance exercises counter saturation.
module tb_sensor_fault_monitor;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [3:0] sens0, sens1;
    logic       en0, en1, clr0, clr1;
    logic       el0, el1, f0, f1;
    logic [7:0] cnt0;
    logic [1:0] cnt1;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sensor_fault_monitor #(.DEBOUNCE_CYCLES(4), .CNT_WIDTH(8)) dut (
        .clk(clk), .n_rst(n_rst), .sensors(sens0), .enable(en0), .clear(clr0),
        .error_live(el0), .fault(f0), .fault_count(cnt0)
    );

    sensor_fault_monitor #(.DEBOUNCE_CYCLES(1), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .n_rst(n_rst), .sensors(sens1), .enable(en1), .clear(clr1),
        .error_live(el1), .fault(f1), .fault_count(cnt1)
    );

    // Reference model: consecutive-error run length, latched fault, event count.
    int         dcyc[2] = '{4, 1};
    int         cmax[2] = '{255, 3};
    int         m_run[2];
    int         m_cnt[2];
    bit         m_fault[2];
    logic [3:0] m_s1[2];
    logic [3:0] m_s2[2];

    function automatic bit ref_err(input logic [3:0] s);
        return s[0] || (s[1] && (s[2] || s[3]));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_run[k] = 0; m_cnt[k] = 0; m_fault[k] = 0;
            m_s1[k] = 4'b0000; m_s2[k] = 4'b0000;
        end
    endtask

    task automatic model_edge(input int k, input logic [3:0] s, input logic en, input logic clr);
        bit err;
        err = ref_err(m_s2[k]);
        if (!en) begin
            m_fault[k] = 0;
            m_run[k]   = 0;
        end else if (m_fault[k]) begin
            if (clr && !err) m_fault[k] = 0;
        end else if (err) begin
            m_run[k]++;
            if (m_run[k] >= dcyc[k]) begin
                m_fault[k] = 1;
                m_run[k]   = 0;
                if (m_cnt[k] < cmax[k]) m_cnt[k]++;
            end
        end else begin
            m_run[k] = 0;
        end
        m_s2[k] = m_s1[k];
        m_s1[k] = s;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        check("el0",  32'(el0),  32'(ref_err(m_s2[0])));
        check("f0",   32'(f0),   32'(m_fault[0]));
        check("cnt0", 32'(cnt0), 32'(m_cnt[0]));
        check("el1",  32'(el1),  32'(ref_err(m_s2[1])));
        check("f1",   32'(f1),   32'(m_fault[1]));
        check("cnt1", 32'(cnt1), 32'(m_cnt[1]));
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge(0, sens0, en0, clr0);
            model_edge(1, sens1, en1, clr1);
            #1;
            check_model();
        end
    endtask

    initial begin
        n_rst = 1'b0;
        sens0 = 4'b0001; sens1 = 4'b0000;
        en0 = 1'b1; en1 = 1'b0; clr0 = 1'b0; clr1 = 1'b0;
        model_reset();
        #12 n_rst = 1'b1;

        // Asynchronous reset while qualifying on 4'b0001
        step(4);
        #2 n_rst = 1'b0;
        #1;
        check("rst_el0", 32'(el0), 32'd0);
        check("rst_f0",  32'(f0),  32'd0);
        check("rst_c0",  32'(cnt0), 32'd0);
        check("rst_f1",  32'(f1),  32'd0);
        model_reset();
        $display("reset: el=%0b fault=%0b count=%0d", el0, f0, cnt0);

        // Qualification on a held 4'b0110
        sens0 = 4'b0110;
        #2 n_rst = 1'b1;
        step(1);
        check("qual_el_e1", 32'(el0), 32'd0);
        step(1);
        check("qual_el_e2", 32'(el0), 32'd1);
        step(3);
        check("qual_f_e5", 32'(f0), 32'd0);
        step(1);
        check("qual_f_e6", 32'(f0), 32'd1);
        check("qual_c_e6", 32'(cnt0), 32'd1);
        $display("qualify: fault=%0b count=%0d", f0, cnt0);

        // Clear while error persists is ignored; clear after error drops works
        sens0 = 4'b0001;
        step(3);
        clr0 = 1'b1; step(1); clr0 = 1'b0;
        check("clr_ignored", 32'(f0), 32'd1);
        sens0 = 4'b0000;
        step(2);
        clr0 = 1'b1; step(1); clr0 = 1'b0;
        check("clr_taken_f", 32'(f0), 32'd0);
        check("clr_taken_c", 32'(cnt0), 32'd1);
        $display("clear: fault=%0b count=%0d", f0, cnt0);

        // Short pulse and non-error pattern never fault
        sens0 = 4'b0001; step(3);
        sens0 = 4'b0000; step(8);
        check("glitch_f", 32'(f0), 32'd0);
        check("glitch_c", 32'(cnt0), 32'd1);
        sens0 = 4'b1100; step(20);
        check("noerr_f", 32'(f0), 32'd0);
        $display("glitch: fault=%0b count=%0d", f0, cnt0);

        // Enable drop during QUAL, then clear+disable together in FAULT
        sens0 = 4'b0110; step(4);
        en0 = 1'b0; step(6);
        check("en_qual_f", 32'(f0), 32'd0);
        check("en_qual_c", 32'(cnt0), 32'd1);
        en0 = 1'b1; step(4);
        check("reent_f", 32'(f0), 32'd1);
        check("reent_c", 32'(cnt0), 32'd2);
        clr0 = 1'b1; en0 = 1'b0; step(1); clr0 = 1'b0;
        check("en_prio_f", 32'(f0), 32'd0);
        step(8);
        check("en_frozen_c", 32'(cnt0), 32'd2);
        en0 = 1'b1;
        $display("enable: fault=%0b count=%0d", f0, cnt0);

        // Saturation of a 2-bit counter with single-cycle debounce
        en1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sens1 = 4'b0001; step(4);
            check("sat_f", 32'(f1), 32'd1);
            check("sat_c", 32'(cnt1), 32'((i + 1 > 3) ? 3 : i + 1));
            sens1 = 4'b0000; step(2);
            clr1 = 1'b1; step(1); clr1 = 1'b0;
            $display("saturate %0d: count=%0d", i, cnt1);
        end

        // Random traffic on both instances
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3, 0) == 0) sens0 = 4'($urandom);
            if ($urandom_range(3, 0) == 0) sens1 = 4'($urandom);
            en0  = ($urandom_range(15, 0) != 0);
            en1  = ($urandom_range(15, 0) != 0);
            clr0 = ($urandom_range(5, 0) == 0);
            clr1 = ($urandom_range(5, 0) == 0);
            step(1);
        end
        $display("random: count0=%0d count1=%0d", cnt0, cnt1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
